// File: rtl/w5300_bus_responder.sv
// w5300_bus_responder: slave-side W5300 16-bit host bus model with register file and access monitor.
// Optional protocol error counter is built when W5300_RESP_ERR_CNT_EN is defined.
module w5300_bus_responder #(
    parameter int          ADDR_BITS  = 6,
    parameter logic [15:0] BOOT_TICKS = 16'd1000,
    parameter logic [9:0]  ID_ADDR    = 10'h3FE,
    parameter logic [15:0] CHIP_ID    = 16'h5300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_rst_n,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [9:0]  addr,
    inout  wire  [15:0] data,
    output logic        ready,
    output logic        mon_wr_valid,
    output logic        mon_rd_valid,
    output logic [9:0]  mon_addr,
    output logic [15:0] mon_data,
    output logic [7:0]  err_cnt
);
    localparam int WORDS = 1 << ADDR_BITS;

    typedef enum logic [2:0] {CHIP_RESET, BOOT, IDLE, WRITE, READ, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [9:0]  addr1_q, addr1_d, addr_p_q, addr_p_d;
    logic [15:0] data1_q, data1_d, data_p_q, data_p_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rd_word_q, rd_word_d;
    logic [15:0] mem_q [WORDS];
    logic [15:0] mem_d [WORDS];
    logic        ready_q, ready_d;
    logic        mon_wr_q, mon_wr_d;
    logic        mon_rd_q, mon_rd_d;
    logic [9:0]  mon_addr_q, mon_addr_d;
    logic [15:0] mon_data_q, mon_data_d;
    logic        w_rst_s, cs_s, rd_s, wr_s;
    logic        in_rng, wr_ok;
    logic [15:0] lookup;

    assign {w_rst_s, cs_s, rd_s, wr_s} = sync2_q;
    assign in_rng = (addr_p_q >> ADDR_BITS) == 10'd0;
    assign wr_ok  = (mon_addr_q != ID_ADDR) && ((mon_addr_q >> ADDR_BITS) == 10'd0);
    assign lookup = (addr_p_q == ID_ADDR) ? CHIP_ID :
                    in_rng ? mem_q[addr_p_q[ADDR_BITS-1:0]] : 16'h0000;

    // Next-state logic: input sync/pipeline, bus FSM, register file and monitor capture.
    always_comb begin
        sync1_d    = {w_rst_n, cs_n, rd_n, wr_n};
        sync2_d    = sync1_q;
        addr1_d    = addr;
        addr_p_d   = addr1_q;
        data1_d    = data;
        data_p_d   = data1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_word_d  = rd_word_q;
        mem_d      = mem_q;
        mon_wr_d   = 1'b0;
        mon_rd_d   = 1'b0;
        mon_addr_d = mon_addr_q;
        mon_data_d = mon_data_q;
        case (state_q)
            CHIP_RESET: begin
                mem_d = '{default: 16'h0000};
                cnt_d = 16'd0;
                if (w_rst_s) state_d = BOOT;
            end
            BOOT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == BOOT_TICKS - 16'd1) state_d = IDLE;
            end
            IDLE: begin
                rd_word_d = lookup;
                if (!cs_s && !wr_s && rd_s) begin
                    state_d    = WRITE;
                    mon_wr_d   = 1'b1;
                    mon_addr_d = addr_p_q;
                    mon_data_d = data_p_q;
                end else if (!cs_s && !rd_s && wr_s) begin
                    state_d    = READ;
                    mon_rd_d   = 1'b1;
                    mon_addr_d = addr_p_q;
                    mon_data_d = lookup;
                end else if (!cs_s && !rd_s && !wr_s) begin
                    state_d = RELEASE;
                end
            end
            WRITE: begin
                // The captured monitor address/data are the write operands, so the commit matches the report.
                if (wr_ok) mem_d[mon_addr_q[ADDR_BITS-1:0]] = mon_data_q;
                state_d = RELEASE;
            end
            READ: state_d = RELEASE;
            RELEASE: if (cs_s || (rd_s && wr_s)) state_d = IDLE;
            default: state_d = CHIP_RESET;
        endcase
        if (!w_rst_s) begin
            state_d    = CHIP_RESET;
            mem_d      = mem_q;
            mon_wr_d   = 1'b0;
            mon_rd_d   = 1'b0;
            mon_addr_d = mon_addr_q;
            mon_data_d = mon_data_q;
        end
        ready_d = state_d inside {IDLE, WRITE, READ, RELEASE};
    end

    // All registers; rst_n returns the block to chip reset with the chip-reset pin held asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CHIP_RESET;
            sync1_q    <= 4'b0111;
            sync2_q    <= 4'b0111;
            addr1_q    <= 10'd0;
            addr_p_q   <= 10'd0;
            data1_q    <= 16'd0;
            data_p_q   <= 16'd0;
            cnt_q      <= 16'd0;
            rd_word_q  <= 16'd0;
            mem_q      <= '{default: 16'h0000};
            ready_q    <= 1'b0;
            mon_wr_q   <= 1'b0;
            mon_rd_q   <= 1'b0;
            mon_addr_q <= 10'd0;
            mon_data_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            addr1_q    <= addr1_d;
            addr_p_q   <= addr_p_d;
            data1_q    <= data1_d;
            data_p_q   <= data_p_d;
            cnt_q      <= cnt_d;
            rd_word_q  <= rd_word_d;
            mem_q      <= mem_d;
            ready_q    <= ready_d;
            mon_wr_q   <= mon_wr_d;
            mon_rd_q   <= mon_rd_d;
            mon_addr_q <= mon_addr_d;
            mon_data_q <= mon_data_d;
        end
    end

`ifdef W5300_RESP_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_inc;

    // Charge an error for strobe collisions and for writes that the register file drops.
    always_comb begin
        err_inc   = (state_q == IDLE) && w_rst_s && !cs_s &&
                    ((!rd_s && !wr_s) || (rd_s && !wr_s && (!in_rng || addr_p_q == ID_ADDR)));
        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Saturating error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    // A chip reset arriving one cycle behind the strobe still suppresses the pulse of the aborted access.
    assign mon_wr_valid = mon_wr_q && w_rst_s;
    assign mon_rd_valid = mon_rd_q && w_rst_s;
    assign mon_addr     = mon_addr_q;
    assign mon_data     = mon_data_q;
    assign ready        = ready_q;
    assign data         = (!cs_n && !rd_n && ready_q) ? rd_word_q : 16'hzzzz;
endmodule

// File: doc/w5300_bus_responder.md
# w5300_bus_responder

Synthesizable slave-side model of the W5300 16-bit direct parallel host bus. It responds to an initiator driving `w_rst_n`, `cs_n`, `rd_n`, `wr_n`, `addr` and `data`. It samples the asynchronous strobes into `clk`, serves reads and writes from a small internal register file, and reports each completed access on a monitor port. It sits on the FPGA in place of the physical chip for loopback bring-up and in benches as the bus counterpart of the host interface.

## Interface
- `ADDR_BITS`, 6: register file holds 2**ADDR_BITS 16-bit words, indexed by `addr[ADDR_BITS-1:0]`.
- `BOOT_TICKS`, 16'd1000: number of `clk` cycles after chip reset release before the block is ready.
- `ID_ADDR`, 10'h3FE: address of the read-only ID word. This address is decoded separately from the register file.
- `CHIP_ID`, 16'h5300: value returned at `ID_ADDR`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `w_rst_n` in 1: chip reset from the host, active low, asynchronous to `clk`.
- `cs_n`, `rd_n`, `wr_n` in 1 each: bus strobes, active low, asynchronous to `clk`.
- `addr` in 10: bus address.
- `data` inout 16: bidirectional data bus. Driven only during reads.
- `ready` out 1: high when boot is complete and bus accesses are served.
- `mon_wr_valid` out 1: one-cycle pulse per accepted write.
- `mon_rd_valid` out 1: one-cycle pulse per served read.
- `mon_addr` out 10: address of the access being reported.
- `mon_data` out 16: data written, or data returned.
- `err_cnt` out 8: saturating protocol error counter. See Configuration.

## Operation
- Input sync:
  - `w_rst_n`, `cs_n`, `rd_n` and `wr_n` each pass through a 2-flop synchronizer, giving `*_s`.
  - `addr` and `data` pass through a 2-stage register pipeline of the same depth, so `addr_p` and `data_p` align with the synchronized strobes.
- Register file:
  - Reset value is all zeros (`rst_n` only; `w_rst_n` also clears it).
  - An address is in range when `addr[9:ADDR_BITS]` is 0.
  - `ID_ADDR` always reads `CHIP_ID`. Writes to it are dropped.
  - Out-of-range reads return 16'h0000. Out-of-range writes are dropped and count as errors.
- States:
  - ChipReset: register file cleared, `ready`=0. Go to Boot when `w_rst_s`=1; the tick counter clears.
  - Boot: tick counter increments. Go to Idle when count reaches BOOT_TICKS-1.
  - Idle: `ready`=1. Each cycle `rd_word` <= the word at `addr_p` (using the ID and out-of-range rules above).
    - If `cs_s`=0 and `wr_s`=0 and `rd_s`=1: go to Write.
    - If `cs_s`=0 and `rd_s`=0 and `wr_s`=1: go to Read.
    - If `cs_s`=0 and both `rd_s` and `wr_s` are 0: go to Release and record an error.
  - Write: commit `data_p` to `addr_p`. Pulse `mon_wr_valid` with `mon_addr`=`addr_p` and `mon_data`=`data_p`. Go to Release.
  - Read: `rd_word` frozen. Pulse `mon_rd_valid` with `mon_data`=`rd_word`. Go to Release.
  - Release: `rd_word` stays frozen. Go to Idle when `cs_s`=1 or when both `rd_s`=1 and `wr_s`=1.
- From any state, `w_rst_s`=0 forces ChipReset on the next edge. This aborts the access in progress: a pending write is not committed and no monitor pulse is issued.
- Bus drive: `data` = `rd_word` when the raw pins satisfy `!cs_n && !rd_n && ready`; otherwise `data` is high-Z.
- `mon_addr` and `mon_data` hold their last value between pulses.

## Timing
- Reset values:
  - `ready`=0, `mon_wr_valid`=0, `mon_rd_valid`=0.
  - `mon_addr`=0, `mon_data`=0, `err_cnt`=0.
  - `data` is high-Z.
  - State is ChipReset.
- `ready` rises BOOT_TICKS+3 cycles after `w_rst_n` rises (2 cycles of sync, the Boot count, then the Idle entry edge).
- Write latency: the strobe-low pin level is seen on edge 2; Write is entered on edge 3. Both the commit and `mon_wr_valid` occur in the cycle after edge 3.
- Read data is valid on `data` no later than 3 edges after the later of the last `addr` change and the falling edge of `rd_n`.
- Host requirements:
  - Strobes held low for ≥4 `clk` cycles.
  - Strobes held high for ≥3 cycles between accesses.
  - `data` stable over the whole `wr_n`-low window.
- A strobe pulse shorter than 2 cycles may be missed. Such a miss is not an error.
- `err_cnt` saturates at 8'hFF.

## Configuration
- `W5300_RESP_ERR_CNT_EN` defined: `err_cnt` increments by 1 for each of the following:
  - `rd_s` and `wr_s` both low while `cs_s` is low.
  - An out-of-range write.
  - A write to `ID_ADDR`.
- `W5300_RESP_ERR_CNT_EN` undefined: the counter logic is absent and `err_cnt` is tied to 8'h00. All other behaviour is identical.

## Test plan
- Reset and boot: `w_rst_n` low for 200 cycles, then high. Expect `ready`=0 until exactly BOOT_TICKS+3 cycles after release, then 1. `data` stays high-Z throughout.
- Write then read: write 16'hA55A to 10'h005 (`wr_n` low 5 cycles), then read 10'h005. Expect one `mon_wr_valid` pulse (addr 005, data A55A), then `data`=16'hA55A while `rd_n` is low, and one `mon_rd_valid` pulse.
- ID and range: read 10'h3FE and expect 16'h5300. Write 16'hFFFF to 10'h3FE, then read it again and expect 16'h5300. Read 10'h040 and expect 16'h0000. With the macro defined, `err_cnt`=1 after this sequence.
- Protocol error: assert `cs_n`, `rd_n` and `wr_n` low together for 6 cycles. Expect no monitor pulse, `data` driven only per the raw-pin rule, and `err_cnt` incremented once (or 0 without the macro).
- Reset mid-write: assert `w_rst_n` low 1 cycle after `wr_n` falls while writing 16'h1234 to 10'h002. Expect no `mon_wr_valid`, and reading 10'h002 after reboot returns 16'h0000.
- Back-to-back reads: read 10'h001 through 10'h010 in sequence with 4-cycle strobes and 3-cycle gaps. Expect 16 `mon_rd_valid` pulses in address order with the correct data.
